rgb_wheel: RTL and testbench
============================

# rgb_wheel

Parametrised RGB colour-wheel sequencer with PWM brightness. It drives the on-board RGB LED in place of the fixed six-colour blinker. It walks the same hue order (red, yellow, green, cyan, blue, magenta) either as hard steps or as a smooth PWM cross-fade, and it can hold or reverse on command. Outputs are active-high. The top level inverts them for the active-low LED pins.

## Interface
- PWM_BITS, 8: duty/phase resolution; MAX = 2^PWM_BITS-1.
- STEP_INTERVAL, 46875: clk cycles per phase increment. Must be ≥1.
- clk  input  1  system clock (12 MHz on board)
- rst  input  1  synchronous, active-high reset
- enable  input  1  1 = hue advances; 0 = hue frozen, PWM keeps running
- mode  input  2  0 STEP, 1 FADE, 2 HOLD, 3 reserved (behaves as HOLD)
- reverse  input  1  0 = forward hue order, 1 = backward
- red, green, blue  output  1 each  PWM channel outputs, active-high
- sector  output  3  current hue sector 0..5 (0 RED … 5 MAGENTA)
- wrap  output  1  one-cycle pulse on sector wrap 5→0 (forward) or 0→5 (reverse)

## Operation
- Tick counter `tick` runs 0..STEP_INTERVAL-1 and wraps. `adv` is asserted on the cycle `tick` = STEP_INTERVAL-1, `enable` = 1 and `mode` ∈ {STEP, FADE}.
- Hue state is `sector` (0..5) plus `phase` (PWM_BITS wide). On `adv`:
  - Forward: if `phase` = MAX, then `phase` ← 0 and `sector` ← (`sector`+1) mod 6. Otherwise `phase`+1.
  - Reverse: if `phase` = 0, then `phase` ← MAX and `sector` ← (`sector`+5) mod 6. Otherwise `phase`-1.
- `wrap` = 1 for exactly the cycle after an `adv` that wraps the sector across 5↔0.
- Sector values 6 and 7 are unreachable. If either is ever present, the next `adv` forces `sector` ← 0.
- Target duty in FADE (up = `phase`, dn = MAX-`phase`; R,G,B):
  - Sector 0: MAX, up, 0
  - Sector 1: dn, MAX, 0
  - Sector 2: 0, MAX, up
  - Sector 3: 0, dn, MAX
  - Sector 4: up, 0, MAX
  - Sector 5: MAX, 0, dn
- STEP duty: the pure sector colour, with `phase` ignored.
  - 0: R
  - 1: R+G
  - 2: G
  - 3: G+B
  - 4: B
  - 5: R+B
  - Each listed channel is MAX; all others are 0.
- HOLD and reserved modes keep the last latched duties.
- PWM: a free-running counter `pwm_cnt` (PWM_BITS wide) wraps MAX→0.
  - Each channel latches its target duty into `duty_r` on the cycle `pwm_cnt` = MAX, so changes take effect only at period boundaries and never glitch mid-period.
  - Channel output ← (`pwm_cnt` < `duty_r`) OR (`duty_r` = MAX). MAX is fully on; 0 is fully off.
- Changes to `mode` and `reverse` are sampled every cycle. They affect `adv` direction immediately and outputs at the next duty latch.
- `reverse` toggling exactly on an `adv` cycle uses the new value.

## Timing
- Reset values: `red`/`green`/`blue` 0, `sector` 0, `wrap` 0, `phase` 0, `tick` 0, `pwm_cnt` 0, all `duty_r` 0.
- First cycle after reset: the first duty latch occurs when `pwm_cnt` = MAX, i.e. 2^PWM_BITS cycles after reset release. The LED is dark until then.
- `rst` mid-operation returns all state to reset values on the next edge. No partial state survives.
- `sector` and `phase` update on the edge at the end of the `adv` cycle.
- PWM output latency: registered, one cycle after the `pwm_cnt` value it reflects.
- A FADE full revolution takes 6·2^PWM_BITS·STEP_INTERVAL cycles. STEP mode revolves at the same rate.

## Structure
- Package `rgb_pkg`:
  - `sector_t` enum RED..MAGENTA (3 bits)
  - `mode_t` enum STEP/FADE/HOLD (2 bits)
  - function `sector_colour(sector_t)`, returning the 3-bit RGB mask
- Sub-module `pwm_channel`, instantiated 3×:
  - Inputs: shared `pwm_cnt`, a target duty, and a latch strobe.
  - Holds `duty_r` and the registered output.
- Top level `rgb_wheel` owns `tick`, `phase`, `sector`, `pwm_cnt` and the duty-mapping logic.

## Test plan
Bench parameters: PWM_BITS=4 (MAX=15), STEP_INTERVAL=3.
- Reset: hold `rst` 5 cycles mid-fade, then release → all outputs 0 and `sector`=0. First RED-high cycle occurs in STEP mode at the period starting 17 cycles after release.
- STEP forward, `enable`=1: `sector` steps 0→1 after 48 cycles.
  - RGB mask follows 100, 110, 010, 011, 001, 101.
  - `wrap` pulses once per 288 cycles.
- FADE, sector 0, `phase`=5: green is high exactly 5 of 16 cycles per period; red is high 16/16; blue is high 0/16.
- Reverse at `sector`=0, `phase`=0 on `adv` → `sector`=5, `phase`=15 and `wrap`=1 for one cycle.
  - Blue duty becomes 0 at the next latch (dn = 0).
- HOLD entered mid-period, then `enable` toggled → `sector`/`phase` frozen. Duties are unchanged across 10 PWM periods.
- Mode switch from FADE to STEP mid-period: outputs stay on the old duty until `pwm_cnt` = 15. From the following period they show the pure sector colour.

Source files
------------

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and helpers for the RGB colour-wheel sequencer.
//   sector_t      - hue sector, RED..MAGENTA (codes 6 and 7 are never produced)
//   mode_t        - sequencer mode; code 3 is reserved and treated as HOLD
//   sector_colour - pure sector colour as a {R,G,B} mask
package rgb_pkg;

  typedef enum logic [2:0] {
    RED     = 3'd0,
    YELLOW  = 3'd1,
    GREEN   = 3'd2,
    CYAN    = 3'd3,
    BLUE    = 3'd4,
    MAGENTA = 3'd5
  } sector_t;

  typedef enum logic [1:0] {
    STEP = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } mode_t;

  // {R,G,B} mask of the fully saturated colour for a sector.
  function automatic logic [2:0] sector_colour(input sector_t s);
    logic [2:0] mask;
    case (s)
      RED:     mask = 3'b100;
      YELLOW:  mask = 3'b110;
      GREEN:   mask = 3'b010;
      CYAN:    mask = 3'b011;
      BLUE:    mask = 3'b001;
      MAGENTA: mask = 3'b101;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output channel.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   pwm_cnt   - shared free-running PWM counter
//   duty      - target duty for the next period
//   latch     - strobe (asserted while pwm_cnt is at its maximum) that captures duty
//   pwm_out   - registered channel output, active-high
module pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                latch,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] Max = '1;

  logic [PWM_BITS-1:0] duty_r;

  // Duty is only captured on the last count of a period, so a new value
  // never cuts a period short or stretches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_r  <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (latch) begin
        duty_r <= duty;
      end
      // Max must be solid on: pwm_cnt < Max alone would drop the last count.
      pwm_out <= (pwm_cnt < duty_r) || (duty_r == Max);
    end
  end

endmodule

// File: rtl/rgb_wheel.sv
// rgb_wheel: RGB colour-wheel sequencer with PWM brightness.
// Walks the hue order red, yellow, green, cyan, blue, magenta either as hard
// steps or as a smooth cross-fade; can hold or reverse. Outputs are active-high.
// Parameters:
//   PWM_BITS      - duty/phase resolution, Max = 2^PWM_BITS-1
//   STEP_INTERVAL - clk cycles per phase increment (>= 1)
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   enable            - 1 = hue advances, 0 = hue frozen (PWM keeps running)
//   mode              - 0 STEP, 1 FADE, 2 HOLD, 3 reserved (as HOLD)
//   reverse           - 0 forward hue order, 1 backward
//   red, green, blue  - PWM channel outputs
//   sector            - current hue sector 0..5
//   wrap              - one-cycle pulse when the sector wraps 5->0 or 0->5
module rgb_wheel
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned STEP_INTERVAL = 46875
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic       reverse,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [2:0] sector,
  output logic       wrap
);

  localparam int unsigned TickW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [TickW-1:0]    TickLast = TickW'(STEP_INTERVAL - 1);
  localparam logic [PWM_BITS-1:0] Max      = '1;

  logic [TickW-1:0]    tick_q, tick_d;
  logic [PWM_BITS-1:0] phase_q, phase_d;
  sector_t             sector_q, sector_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                wrap_q, wrap_d;

  logic                run_mode;
  logic                fade_mode;
  logic                adv;
  logic                latch;
  logic [PWM_BITS-1:0] up, dn;
  logic [2:0]          mask;
  logic [PWM_BITS-1:0] r_tgt, g_tgt, b_tgt;

  // HOLD and the reserved code both fall outside run_mode.
  assign run_mode  = (mode == STEP) || (mode == FADE);
  assign fade_mode = (mode == FADE);
  assign adv       = (tick_q == TickLast) && enable && run_mode;
  // Suppressing the latch outside STEP/FADE is what makes HOLD keep the
  // last latched duties.
  assign latch     = (pwm_cnt_q == Max) && run_mode;

  always_comb begin
    tick_d = (tick_q == TickLast) ? '0 : tick_q + 1'b1;
  end

  // Hue walk: phase sweeps 0..Max within a sector, then carries into sector.
  always_comb begin
    phase_d  = phase_q;
    sector_d = sector_q;
    wrap_d   = 1'b0;
    if (adv) begin
      if (sector_q > MAGENTA) begin
        // Recovery from an illegal code: restart the wheel at red.
        sector_d = RED;
        phase_d  = '0;
      end else if (!reverse) begin
        if (phase_q == Max) begin
          phase_d = '0;
          if (sector_q == MAGENTA) begin
            sector_d = RED;
            wrap_d   = 1'b1;
          end else begin
            sector_d = sector_t'(sector_q + 3'd1);
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end else begin
        if (phase_q == '0) begin
          phase_d = Max;
          if (sector_q == RED) begin
            sector_d = MAGENTA;
            wrap_d   = 1'b1;
          end else begin
            sector_d = sector_t'(sector_q - 3'd1);
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
    end
  end

  // Target duties: FADE ramps one channel per sector, STEP shows pure colour.
  assign up   = phase_q;
  assign dn   = Max - phase_q;
  assign mask = sector_colour(sector_q);

  always_comb begin
    r_tgt = '0;
    g_tgt = '0;
    b_tgt = '0;
    if (fade_mode) begin
      case (sector_q)
        RED:     begin r_tgt = Max; g_tgt = up;  b_tgt = '0;  end
        YELLOW:  begin r_tgt = dn;  g_tgt = Max; b_tgt = '0;  end
        GREEN:   begin r_tgt = '0;  g_tgt = Max; b_tgt = up;  end
        CYAN:    begin r_tgt = '0;  g_tgt = dn;  b_tgt = Max; end
        BLUE:    begin r_tgt = up;  g_tgt = '0;  b_tgt = Max; end
        MAGENTA: begin r_tgt = Max; g_tgt = '0;  b_tgt = dn;  end
        default: begin r_tgt = '0;  g_tgt = '0;  b_tgt = '0;  end
      endcase
    end else begin
      r_tgt = mask[2] ? Max : '0;
      g_tgt = mask[1] ? Max : '0;
      b_tgt = mask[0] ? Max : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= '0;
      phase_q   <= '0;
      sector_q  <= RED;
      pwm_cnt_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      phase_q   <= phase_d;
      sector_q  <= sector_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      wrap_q    <= wrap_d;
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt_q),
    .duty    (r_tgt),
    .latch   (latch),
    .pwm_out (red)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt_q),
    .duty    (g_tgt),
    .latch   (latch),
    .pwm_out (green)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt_q),
    .duty    (b_tgt),
    .latch   (latch),
    .pwm_out (blue)
  );

  assign sector = sector_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_rgb_wheel.sv
// tb_rgb_wheel: directed self-checking bench for rgb_wheel with PWM_BITS=4
// (Max=15) and STEP_INTERVAL=3. cyc counts rising edges since the last reset
// release; all sampling and driving happens 1 time unit after an edge.
module tb_rgb_wheel;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic       reverse;
  logic       red, green, blue;
  logic [2:0] sector;
  logic       wrap;

  int cyc;
  int total;
  int passed;

  always #5 clk = ~clk;

  rgb_wheel #(
    .PWM_BITS      (4),
    .STEP_INTERVAL (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .mode    (mode),
    .reverse (reverse),
    .red     (red),
    .green   (green),
    .blue    (blue),
    .sector  (sector),
    .wrap    (wrap)
  );

  task automatic step1();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step1();
  endtask

  task automatic count_high(input int n, output int nr, output int ng, output int nb);
    nr = 0;
    ng = 0;
    nb = 0;
    repeat (n) begin
      step1();
      nr += int'(red);
      ng += int'(green);
      nb += int'(blue);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    mode    = 2'd1;
    enable  = 1'b1;
    reverse = 1'b0;
    cyc     = 0;
    repeat (3) step1();
    rst = 1'b0;
    repeat (37) step1();
    rst = 1'b1;
    repeat (5) step1();
    total++;
    if ({red, green, blue} !== 3'b000) $display("FAIL reset_rgb: got %b expected 000", {red, green, blue});
    else passed++;
    total++;
    if (sector !== 3'd0) $display("FAIL reset_sector: got %0d expected 0", sector);
    else passed++;
    total++;
    if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", wrap);
    else passed++;
    rst  = 1'b0;
    mode = 2'd0;
    cyc  = 0;
    run_to(16);
    total++;
    if ({red, green, blue} !== 3'b000) $display("FAIL dark_before_latch: got %b expected 000", {red, green, blue});
    else passed++;
    run_to(17);
    total++;
    if ({red, green, blue} !== 3'b100) $display("FAIL first_red: got %b expected 100", {red, green, blue});
    else passed++;
  endtask

  task automatic test_step_forward();
    logic [2:0] masks [6];
    int n;
    masks = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    run_to(20);
    total++;
    if ({red, green, blue} !== masks[0]) $display("FAIL step_mask0: got %b expected %b", {red, green, blue}, masks[0]);
    else passed++;
    run_to(47);
    total++;
    if (sector !== 3'd0) $display("FAIL step_sector_pre: got %0d expected 0", sector);
    else passed++;
    run_to(48);
    total++;
    if (sector !== 3'd1) $display("FAIL step_sector_48: got %0d expected 1", sector);
    else passed++;
    for (int s = 1; s < 6; s++) begin
      run_to(48 * s + 20);
      total++;
      if (sector !== 3'(s)) $display("FAIL step_sector%0d: got %0d expected %0d", s, sector, s);
      else passed++;
      total++;
      if ({red, green, blue} !== masks[s]) $display("FAIL step_mask%0d: got %b expected %b", s, {red, green, blue}, masks[s]);
      else passed++;
    end
    run_to(287);
    total++;
    if (wrap !== 1'b0 || sector !== 3'd5) $display("FAIL pre_wrap: got wrap=%b sector=%0d expected wrap=0 sector=5", wrap, sector);
    else passed++;
    run_to(288);
    total++;
    if (wrap !== 1'b1 || sector !== 3'd0) $display("FAIL wrap_fwd: got wrap=%b sector=%0d expected wrap=1 sector=0", wrap, sector);
    else passed++;
    run_to(289);
    total++;
    if (wrap !== 1'b0) $display("FAIL wrap_one_cycle: got %b expected 0", wrap);
    else passed++;
    n = 0;
    while (cyc < 576) begin
      step1();
      n += int'(wrap);
    end
    total++;
    if (n !== 1) $display("FAIL wrap_per_rev: got %0d expected 1", n);
    else passed++;
  endtask

  task automatic test_fade();
    int nr, ng, nb;
    run_to(591);
    mode   = 2'd1;
    enable = 1'b0;
    run_to(592);
    count_high(16, nr, ng, nb);
    total++;
    if (ng !== 5) $display("FAIL fade_green: got %0d expected 5", ng);
    else passed++;
    total++;
    if (nr !== 16) $display("FAIL fade_red: got %0d expected 16", nr);
    else passed++;
    total++;
    if (nb !== 0) $display("FAIL fade_blue: got %0d expected 0", nb);
    else passed++;
  endtask

  task automatic test_reverse();
    int nr, ng, nb;
    run_to(609);
    reverse = 1'b1;
    enable  = 1'b1;
    run_to(626);
    total++;
    if (sector !== 3'd0 || wrap !== 1'b0) $display("FAIL rev_pre: got sector=%0d wrap=%b expected sector=0 wrap=0", sector, wrap);
    else passed++;
    run_to(627);
    enable = 1'b0;
    total++;
    if (sector !== 3'd5 || wrap !== 1'b1) $display("FAIL rev_wrap: got sector=%0d wrap=%b expected sector=5 wrap=1", sector, wrap);
    else passed++;
    run_to(628);
    total++;
    if (wrap !== 1'b0) $display("FAIL rev_wrap_pulse: got %b expected 0", wrap);
    else passed++;
    run_to(640);
    count_high(16, nr, ng, nb);
    total++;
    if (nb !== 0 || nr !== 16 || ng !== 0) $display("FAIL rev_duty: got r=%0d g=%0d b=%0d expected r=16 g=0 b=0", nr, ng, nb);
    else passed++;
    // Phase must be Max: one forward step wraps straight back to red.
    reverse = 1'b0;
    enable  = 1'b1;
    run_to(657);
    total++;
    if (sector !== 3'd0 || wrap !== 1'b1) $display("FAIL rev_phase_max: got sector=%0d wrap=%b expected sector=0 wrap=1", sector, wrap);
    else passed++;
  endtask

  task automatic test_hold();
    int nr, ng, nb;
    run_to(680);
    mode = 2'd2;
    run_to(685);
    enable = 1'b0;
    run_to(688);
    enable = 1'b1;
    count_high(40, nr, ng, nb);
    enable = 1'b0;
    begin
      int r2, g2, b2;
      count_high(60, r2, g2, b2);
      nr += r2; ng += g2; nb += b2;
      enable = 1'b1;
      count_high(60, r2, g2, b2);
      nr += r2; ng += g2; nb += b2;
    end
    total++;
    if (ng !== 40) $display("FAIL hold_green: got %0d expected 40", ng);
    else passed++;
    total++;
    if (nr !== 160 || nb !== 0) $display("FAIL hold_rb: got r=%0d b=%0d expected r=160 b=0", nr, nb);
    else passed++;
    total++;
    if (sector !== 3'd0 || wrap !== 1'b0) $display("FAIL hold_sector: got sector=%0d wrap=%b expected 0/0", sector, wrap);
    else passed++;
  endtask

  task automatic test_mode_switch();
    int nr, ng, nb, r2, g2, b2;
    mode   = 2'd1;
    enable = 1'b0;
    run_to(864);
    count_high(8, nr, ng, nb);
    mode = 2'd0;
    count_high(8, r2, g2, b2);
    ng += g2;
    total++;
    if (ng !== 7) $display("FAIL switch_old_duty: got green=%0d expected 7", ng);
    else passed++;
    count_high(16, nr, ng, nb);
    total++;
    if (nr !== 16 || ng !== 0 || nb !== 0) $display("FAIL switch_step: got r=%0d g=%0d b=%0d expected 16/0/0", nr, ng, nb);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_step_forward();
    test_fade();
    test_reverse();
    test_hold();
    test_mode_switch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
